// File: rtl/stack_pkg.sv
// Shared types and defaults for the arbitrated stack.
package stack_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;
  localparam int STACK_WIDTH = 32;
  localparam int STACK_DEPTH = 16;
endpackage

// File: rtl/stack.sv
// LIFO storage with a synchronous active-high clear; data_out always shows the top entry.
module stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_m1;

  assign empty = (sp == '0);
  assign full  = (sp == CW'(DEPTH));
  assign sp_m1 = sp - CW'(1);
  assign data_out = empty ? '0 : mem[sp_m1[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst)                 sp <= '0;
    else if (push && !full)  sp <= sp + CW'(1);
    else if (pop && !empty)  sp <= sp_m1;
  end

  // Storage carries no reset; occupancy is tracked by sp alone.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem[sp[AW-1:0]] <= data_in;
  end
endmodule

// File: rtl/stack_arb.sv
// Round-robin arbiter in front of a shared stack, with a RUN/FLUSH/DRAIN flush sequencer.
module stack_arb
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int NREQ  = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_pop,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [CW-1:0]         count,
  output logic                  busy
);
  state_t                       state, state_nx;
  logic [IW-1:0]                rr_ptr;
  logic [NREQ-1:0][WIDTH-1:0]   rd;
  logic [NREQ-1:0]              elig;
  logic                         gnt_any;
  logic [IW-1:0]                gnt_idx;
  logic                         push, pop, empty, full;
  logic [WIDTH-1:0]             top;

  assign rd   = req_data;
  assign busy = (state != RUN);

  // Flush wins over any request in the same cycle; nothing is granted in reset.
  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign elig[i] = rst && req_valid[i] && (req_pop[i] ? !empty : !full)
                     && (state == RUN) && !flush;
    assign req_ready[i] = gnt_any && (gnt_idx == IW'(i));
  end

  always_comb begin : rr_sel
    int j;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && elig[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  assign push = gnt_any && !req_pop[gnt_idx];
  assign pop  = gnt_any &&  req_pop[gnt_idx];

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (flush) state_nx = FLUSH;
      FLUSH:   state_nx = DRAIN;
      DRAIN:   if (!flush) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      rr_ptr    <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= pop;
      rsp_id    <= pop ? gnt_idx : '0;
      rsp_data  <= pop ? top : '0;
      if (gnt_any)
        rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      if (state == FLUSH) count <= '0;
      else if (push)      count <= count + CW'(1);
      else if (pop)       count <= count - CW'(1);
    end
  end

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk      (clk),
    .rst      (!rst || (state == FLUSH)),
    .push     (push),
    .pop      (pop),
    .data_in  (rd[gnt_idx]),
    .data_out (top),
    .empty    (empty),
    .full     (full)
  );
endmodule

// File: tb/tb_stack_arb.sv
// Directed checks of arbitration, LIFO order, flush sequencing and reset for stack_arb.
module tb_stack_arb;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int NREQ  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [NREQ-1:0]       req_valid, req_pop, req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  rsp_valid, busy;
  logic [0:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic [4:0]            count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stack_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_pop(req_pop),
    .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .count(count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; req_valid = '0; req_pop = '0; req_data = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; req_pop = '0; req_data = '0;
    req_valid = 2'b11;
    tick(); tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 1'b0);

    // Scenario 1: push A (r0), push B (r1), pop r0 -> B, pop r1 -> A
    do_reset();
    req_data = {32'hB, 32'hA};
    req_valid = 2'b01; #1;
    chk("s1_ready_push0", req_ready, 2'b01);
    tick(); chk("s1_count1", count, 1);
    req_valid = 2'b10; #1;
    chk("s1_ready_push1", req_ready, 2'b10);
    tick(); chk("s1_count2", count, 2);
    req_valid = 2'b01; req_pop = 2'b01; #1;
    chk("s1_ready_pop0", req_ready, 2'b01);
    tick();
    chk("s1_rsp_valid", rsp_valid, 1'b1);
    chk("s1_rsp_id", rsp_id, 1'b0);
    chk("s1_rsp_data", rsp_data, 32'hB);
    chk("s1_count3", count, 1);
    req_valid = 2'b10; req_pop = 2'b10; #1;
    chk("s1_ready_pop1", req_ready, 2'b10);
    tick();
    chk("s1_rsp_id1", rsp_id, 1'b1);
    chk("s1_rsp_data1", rsp_data, 32'hA);
    chk("s1_count4", count, 0);
    req_valid = '0; req_pop = '0;
    tick();
    chk("s1_rsp_idle", rsp_valid, 1'b0);
    chk("s1_rsp_data_idle", rsp_data, 0);

    // Scenario 2: both push continuously, grants alternate, stack fills
    do_reset();
    req_data = {32'h20, 32'h10};
    req_valid = 2'b11; req_pop = 2'b00;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk($sformatf("s2_alt%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    chk("s2_count_full", count, DEPTH);
    chk("s2_ready_full", req_ready, 2'b00);
    // Drain through r0: LIFO order returns 0x20 first
    req_valid = 2'b01; req_pop = 2'b01;
    for (int j = 0; j < DEPTH; j++) begin
      tick();
      chk($sformatf("s2_pop%0d", j), rsp_data, (j % 2 == 0) ? 32'h20 : 32'h10);
    end
    chk("s2_count_empty", count, 0);
    chk("s2_ready_empty", req_ready, 2'b00);
    req_valid = '0; req_pop = '0;

    // Scenario 3: empty stack, r0 pop stalls while r1 push proceeds
    do_reset();
    req_data = {32'h5, 32'h0};
    req_valid = 2'b11; req_pop = 2'b01; #1;
    chk("s3_ready_push", req_ready, 2'b10);
    tick();
    chk("s3_count", count, 1);
    chk("s3_no_rsp", rsp_valid, 1'b0);
    req_valid = 2'b01; #1;
    chk("s3_ready_pop", req_ready, 2'b01);
    tick();
    chk("s3_rsp_valid", rsp_valid, 1'b1);
    chk("s3_rsp_id", rsp_id, 1'b0);
    chk("s3_rsp_data", rsp_data, 32'h5);
    req_valid = '0; req_pop = '0;

    // Scenario 4: 3 entries, flush held 3 cycles
    do_reset();
    req_data = {32'h0, 32'h77};
    req_valid = 2'b01;
    tick(); tick(); tick();
    chk("s4_count3", count, 3);
    flush = 1'b1; #1;
    chk("s4_flush_prio", req_ready, 2'b00);
    tick();
    chk("s4_busy1", busy, 1'b1);
    chk("s4_count_hold", count, 3);
    chk("s4_ready_flush", req_ready, 2'b00);
    tick();
    chk("s4_count0", count, 0);
    chk("s4_busy2", busy, 1'b1);
    tick();
    chk("s4_busy3", busy, 1'b1);
    chk("s4_ready_drain", req_ready, 2'b00);
    flush = 1'b0; #1;
    chk("s4_ready_drop", req_ready, 2'b00);
    tick();
    chk("s4_busy_done", busy, 1'b0);
    chk("s4_ready_run", req_ready, 2'b01);
    chk("s4_count_after", count, 0);
    req_valid = '0;

    // Scenario 5: reset right after a pop grant discards the response
    do_reset();
    req_data = {32'h0, 32'h33};
    req_valid = 2'b01; tick();
    req_pop = 2'b01; tick();
    rst = 1'b0; req_valid = '0; req_pop = '0;
    tick();
    chk("s5_rsp_valid", rsp_valid, 1'b0);
    chk("s5_rsp_data", rsp_data, 0);
    chk("s5_rsp_id", rsp_id, 1'b0);
    chk("s5_count", count, 0);
    chk("s5_busy", busy, 1'b0);
    rst = 1'b1;

    // Scenario 6: pop then flush; response still delivered, later pop stalls
    do_reset();
    req_data = {32'h0, 32'h7};
    req_valid = 2'b01; tick();
    req_pop = 2'b01; tick();
    req_valid = '0; req_pop = '0; flush = 1'b1; #1;
    chk("s6_rsp_valid", rsp_valid, 1'b1);
    chk("s6_rsp_data", rsp_data, 32'h7);
    tick(); tick();
    flush = 1'b0;
    tick();
    chk("s6_run", busy, 1'b0);
    req_valid = 2'b10; req_pop = 2'b10; #1;
    chk("s6_pop_stall", req_ready, 2'b00);
    tick();
    chk("s6_no_rsp", rsp_valid, 1'b0);
    req_valid = '0; req_pop = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
